// File: rtl/spi_tx_master_if.sv
// spi_tx_master_if: word handshake and serial pins of the SPI transmitter; MISO readback signals exist only with SPI_READBACK_EN
interface spi_tx_master_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              sclk;
  logic              dout;
  logic              sync_n;
`ifdef SPI_READBACK_EN
  logic              din;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  modport master (
    input  tx_data, tx_valid, din,
    output tx_ready, busy, sclk, dout, sync_n, rx_data, rx_valid
  );
  modport slave (
    output tx_data, tx_valid, din,
    input  tx_ready, busy, sclk, dout, sync_n, rx_data, rx_valid
  );
`else
  modport master (
    input  tx_data, tx_valid,
    output tx_ready, busy, sclk, dout, sync_n
  );
  modport slave (
    output tx_data, tx_valid,
    input  tx_ready, busy, sclk, dout, sync_n
  );
`endif
endinterface

// File: rtl/spi_tx_master.sv
// spi_tx_master: SPI master transmitter, one word per valid/ready accept, sync_n framing, inter-frame gap; MISO readback with SPI_READBACK_EN
module spi_tx_master #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int GAP_CYC   = 20,
  parameter bit CPOL      = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  spi_tx_master_if.master bus
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int HW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     bc_q, bc_d;
  logic [HW-1:0]     hc_q, hc_d;
  logic [GW-1:0]     gc_q, gc_d;
  logic              ph_q, ph_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              sclk_q, sclk_d;
  logic              dout_q, dout_d;
  logic              sync_n_q, sync_n_d;
  logic              half_end, bit_end;
`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
`endif
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction
  // next state and registered outputs; ph_q selects the first (CPOL) or second (~CPOL) half of a bit
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bc_d       = bc_q;
    hc_d       = hc_q;
    gc_d       = gc_q;
    ph_d       = ph_q;
    tx_ready_d = 1'b0;
    busy_d     = 1'b1;
    sclk_d     = CPOL;
    dout_d     = 1'b0;
    sync_n_d   = 1'b1;
    half_end   = hc_q == HW'(CLK_DIV - 1);
    bit_end    = state_q == SHIFT && half_end && ph_q;
`ifdef SPI_READBACK_EN
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (bus.tx_valid) begin
          state_d    = SHIFT;
          sr_d       = bus.tx_data;
          bc_d       = BW'(DATA_W);
          hc_d       = '0;
          ph_d       = 1'b0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
          sync_n_d   = 1'b0;
          dout_d     = first_bit(bus.tx_data);
        end
      end
      SHIFT: begin
        sync_n_d = 1'b0;
        dout_d   = dout_q;
        hc_d     = half_end ? '0 : hc_q + 1'b1;
        sclk_d   = ph_q ? ~CPOL : CPOL;
        if (half_end && !ph_q) begin
          ph_d   = 1'b1;
          sclk_d = ~CPOL;
        end else if (bit_end) begin
          ph_d   = 1'b0;
          sclk_d = CPOL;
          bc_d   = bc_q == '0 ? bc_q : bc_q - 1'b1;
          sr_d   = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
          dout_d = first_bit(sr_d);
`ifdef SPI_READBACK_EN
          rx_sr_d = MSB_FIRST ? {rx_sr_q[DATA_W-2:0], bus.din} : {bus.din, rx_sr_q[DATA_W-1:1]};
`endif
          if (bc_q == BW'(1)) begin
            state_d  = GAP;
            sync_n_d = 1'b1;
            dout_d   = 1'b0;
            gc_d     = GW'(GAP_CYC - 1);
`ifdef SPI_READBACK_EN
            rx_data_d  = rx_sr_d;
            rx_valid_d = 1'b1;
`endif
          end
        end
      end
      GAP: begin
        gc_d = gc_q == '0 ? gc_q : gc_q - 1'b1;
        if (gc_q == '0) begin
          state_d    = IDLE;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end
  // state and output registers; reset abandons any frame in flight immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bc_q       <= '0;
      hc_q       <= '0;
      gc_q       <= '0;
      ph_q       <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      sclk_q     <= CPOL;
      dout_q     <= 1'b0;
      sync_n_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bc_q       <= bc_d;
      hc_q       <= hc_d;
      gc_q       <= gc_d;
      ph_q       <= ph_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      dout_q     <= dout_d;
      sync_n_q   <= sync_n_d;
    end
  end
  assign bus.tx_ready = tx_ready_q;
  assign bus.busy     = busy_q;
  assign bus.sclk     = sclk_q;
  assign bus.dout     = dout_q;
  assign bus.sync_n   = sync_n_q;
`ifdef SPI_READBACK_EN
  // receive registers; rx_data only moves when a frame completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`endif
endmodule

// File: tb/tb_spi_tx_master.sv
// tb_spi_tx_master: directed bench for spi_tx_master, default 8-bit instance plus a 12-bit LSB-first CPOL=0 instance; readback checks with SPI_READBACK_EN
module tb_spi_tx_master;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   passed = 0;
  spi_tx_master_if #(.DATA_W(8))  bus0 ();
  spi_tx_master_if #(.DATA_W(12)) bus1 ();
  spi_tx_master u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  spi_tx_master #(.DATA_W(12), .CLK_DIV(1), .CPOL(1'b0), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
`ifdef SPI_READBACK_EN
  assign bus0.din = bus0.dout;
  assign bus1.din = bus1.dout;
`endif
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus0.tx_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_ready_wait"}, bus0.tx_ready, 1);
  endtask
  task automatic frame8(input string tag, input logic [7:0] w);
    wait_ready(tag);
    bus0.tx_data  = w;
    bus0.tx_valid = 1'b1;
    step();
    bus0.tx_valid = 1'b0;
    bus0.tx_data  = ~w;
    chk({tag, "_start"}, {bus0.busy, bus0.tx_ready}, 2'b10);
    for (int i = 0; i < 32; i++) begin
      chk({tag, "_shift"}, {bus0.sync_n, bus0.sclk, bus0.dout}, {1'b0, (i % 4) < 2, w[7 - i / 4]});
      step();
    end
    for (int i = 0; i < 20; i++) begin
      chk({tag, "_gap"}, {bus0.sync_n, bus0.sclk, bus0.dout, bus0.busy, bus0.tx_ready}, 5'b11010);
      step();
    end
    chk({tag, "_idle"}, {bus0.busy, bus0.tx_ready}, 2'b01);
  endtask
  initial begin
    logic [11:0] w12;
    logic [7:0]  w1, w2;
    int          n;
    rst_n         = 1'b0;
    bus0.tx_valid = 1'b0;
    bus0.tx_data  = '0;
    bus1.tx_valid = 1'b0;
    bus1.tx_data  = '0;
    step();
    step();
    chk("rst_u0", {bus0.tx_ready, bus0.busy, bus0.sclk, bus0.dout, bus0.sync_n}, 5'b10101);
    chk("rst_u1", {bus1.tx_ready, bus1.busy, bus1.sclk, bus1.dout, bus1.sync_n}, 5'b10001);
`ifdef SPI_READBACK_EN
    chk("rst_rx", {bus0.rx_valid, bus0.rx_data}, 9'h000);
`endif
    rst_n = 1'b1;
    step();
    step();
    chk("idle_hold", {bus0.tx_ready, bus0.busy, bus0.sync_n}, 3'b101);
    frame8("a5", 8'hA5);
    w12 = 12'h3C1;
    bus1.tx_data  = w12;
    bus1.tx_valid = 1'b1;
    step();
    bus1.tx_valid = 1'b0;
    bus1.tx_data  = 12'hFFF;
    for (int i = 0; i < 24; i++) begin
      chk("w12_shift", {bus1.sync_n, bus1.sclk, bus1.dout}, {1'b0, (i % 2) == 1, w12[i / 2]});
      step();
    end
    chk("w12_end", {bus1.sync_n, bus1.sclk, bus1.dout, bus1.busy}, 4'b1001);
    wait_ready("b2b");
    bus0.tx_data  = 8'h01;
    bus0.tx_valid = 1'b1;
    step();
    bus0.tx_data = 8'h80;
    n  = 0;
    w1 = '0;
    while (n < 200) begin
      if (n < 32 && n % 4 == 1) w1 = {w1[6:0], bus0.dout};
      if (bus0.tx_ready) break;
      step();
      n++;
    end
    chk("b2b_spacing", n + 1, 53);
    chk("b2b_word1", w1, 8'h01);
    step();
    bus0.tx_valid = 1'b0;
    bus0.tx_data  = 8'h33;
    w2 = '0;
    for (int i = 0; i < 32; i++) begin
      if (i % 4 == 1) w2 = {w2[6:0], bus0.dout};
      step();
    end
    chk("b2b_word2", w2, 8'h80);
    wait_ready("abort");
    bus0.tx_data  = 8'hC3;
    bus0.tx_valid = 1'b1;
    step();
    bus0.tx_valid = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("abort_mid", {bus0.sync_n, bus0.busy}, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_async", {bus0.tx_ready, bus0.busy, bus0.sclk, bus0.dout, bus0.sync_n}, 5'b10101);
    step();
    rst_n = 1'b1;
    step();
    chk("abort_release", {bus0.tx_ready, bus0.busy, bus0.sync_n}, 3'b101);
    frame8("after_rst", 8'h96);
`ifdef SPI_READBACK_EN
    wait_ready("rb");
    bus0.tx_data  = 8'h5A;
    bus0.tx_valid = 1'b1;
    step();
    bus0.tx_valid = 1'b0;
    n  = 0;
    w1 = '0;
    for (int i = 0; i < 40; i++) begin
      if (bus0.rx_valid === 1'b1) begin
        n++;
        if (n == 1) w1 = 8'(i);
        if (n == 1) chk("rb_sync_rise", bus0.sync_n, 1);
      end
      step();
    end
    chk("rb_pulses", n, 1);
    chk("rb_pulse_at", w1, 8'd32);
    chk("rb_data", bus0.rx_data, 8'h5A);
    wait_ready("rb_abort");
    bus0.tx_data  = 8'hFF;
    bus0.tx_valid = 1'b1;
    step();
    bus0.tx_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus0.rx_valid === 1'b1) n++;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    step();
    chk("rb_abort_pulses", n, 0);
    chk("rb_abort_data", {bus0.rx_valid, bus0.rx_data}, 9'h000);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
